// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump reader.
package regfile_dump_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    FETCH  = 3'd2,
    SEND   = 3'd3,
    DONE   = 3'd4
  } dump_state_t;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;
  localparam int         BYTES_PER_REG       = 4;

endpackage

// File: rtl/regfile_dump_reader_serializer.sv
// Loads a 32-bit word and hands it out MSB byte first over valid/ready.
module word_byte_serializer
  import regfile_dump_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        ready,
  output logic [7:0]  data,
  output logic        valid,
  output logic        last
);

  logic [31:0] word;
  logic [1:0]  byte_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      word     <= '0;
      byte_cnt <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      word     <= load_word;
      byte_cnt <= '0;
      valid    <= 1'b1;
    end else if (valid && ready) begin
      if (last) valid <= 1'b0;
      else      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  always_comb begin
    data = word[31:24];
    case (byte_cnt)
      2'd0: data = word[31:24];
      2'd1: data = word[23:16];
      2'd2: data = word[15:8];
      2'd3: data = word[7:0];
      default: data = word[31:24];
    endcase
  end

  assign last = (byte_cnt == 2'(BYTES_PER_REG - 1));

endmodule

// File: rtl/regfile_dump_reader.sv
// Freezes the core and streams registers FIRST_REG..LAST_REG as a framed byte dump.
//
// state  | meaning
// IDLE   | waiting for start, core runs
// HEADER | frame marker byte offered
// FETCH  | rd_addr=idx, word captured at end of cycle
// SEND   | 4 bytes of the captured word, MSB first
// DONE   | one-cycle done pulse, core still held
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int         FIRST_REG   = 0,
  parameter int         LAST_REG    = 31,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        hold_cpu,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  dump_state_t state, state_d;
  logic [4:0]  idx;
  logic [7:0]  ser_data;
  logic        ser_valid;
  logic        ser_last;
  logic        word_sent;

  assign word_sent = (state == SEND) && ser_valid && tx_ready && ser_last;

  word_byte_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (state == FETCH),
    .load_word (rd_data),
    .ready     (tx_ready),
    .data      (ser_data),
    .valid     (ser_valid),
    .last      (ser_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = HEADER;
      HEADER:  if (tx_ready) state_d = FETCH;
      FETCH:   state_d = SEND;
      SEND:    if (word_sent) state_d = (idx == LAST_IDX) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // idx stops at LAST_IDX, so it can never wrap past 31
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx <= '0;
    end else if ((state == IDLE) && start) begin
      idx <= FIRST_IDX;
    end else if (word_sent && (idx != LAST_IDX)) begin
      idx <= idx + 5'd1;
    end
  end

  always_comb begin
    rd_addr  = (state == IDLE) ? 5'd0 : idx;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state != IDLE);
    hold_cpu = (state != IDLE);
    done     = (state == DONE);
    case (state)
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_BYTE;
      end
      SEND: begin
        tx_valid = ser_valid;
        tx_data  = ser_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench: full 32-register dump, single-register dump, stalls, reset and restart cases.
module tb_regfile_dump_reader;

  localparam int A_FIRST = 0;
  localparam int A_LAST  = 31;
  localparam int A_TOTAL = 1 + 4 * (A_LAST - A_FIRST + 1);
  localparam int B_FIRST = 5;
  localparam int B_LAST  = 5;
  localparam int B_TOTAL = 1 + 4 * (B_LAST - B_FIRST + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, start_b;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_valid_a, tx_valid_b;
  logic        tx_ready_a, tx_ready_b;
  logic        hold_cpu_a, hold_cpu_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;

  logic [31:0] regs [32];
  assign rd_data_a = (rd_addr_a == 5'd0) ? 32'd0 : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 5'd0) ? 32'd0 : regs[rd_addr_b];

  regfile_dump_reader #(.FIRST_REG(A_FIRST), .LAST_REG(A_LAST), .HEADER_BYTE(8'hA5)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .hold_cpu(hold_cpu_a), .busy(busy_a), .done(done_a));

  regfile_dump_reader #(.FIRST_REG(B_FIRST), .LAST_REG(B_LAST), .HEADER_BYTE(8'hA5)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .hold_cpu(hold_cpu_b), .busy(busy_b), .done(done_b));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Byte i of a frame: header, then each register's word split MSB first.
  function automatic logic [7:0] exp_byte(input int first, input int i);
    int j;
    int r;
    logic [31:0] w;
    if (i == 0) return 8'hA5;
    j = i - 1;
    r = first + j / 4;
    w = (r == 0) ? 32'd0 : regs[r];
    return 8'((w >> (24 - 8 * (j % 4))) & 32'hFF);
  endfunction

  int ptr_a = 0, done_cnt_a = 0, ptr_b = 0, done_cnt_b = 0;
  bit stall_a = 0, stall_b = 0;
  logic [7:0] held_a, held_b;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      ptr_a = 0;
      stall_a = 0;
    end else begin
      if (stall_a) check("a_stall_stable", {23'd0, tx_valid_a, tx_data_a}, {23'd0, 1'b1, held_a});
      if (tx_valid_a && tx_ready_a) begin
        if (ptr_a >= A_TOTAL) check("a_extra_byte", ptr_a, A_TOTAL - 1);
        else check("a_byte", tx_data_a, exp_byte(A_FIRST, ptr_a));
        ptr_a++;
      end
      stall_a = tx_valid_a && !tx_ready_a;
      held_a  = tx_data_a;
      check("a_hold_eq_busy", hold_cpu_a, busy_a);
      if (ptr_a > 0) check("a_hold_mid_frame", hold_cpu_a, 1);
      if (done_a) begin
        check("a_done_after_last", ptr_a, A_TOTAL);
        done_cnt_a++;
        ptr_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      ptr_b = 0;
      stall_b = 0;
    end else begin
      if (stall_b) check("b_stall_stable", {23'd0, tx_valid_b, tx_data_b}, {23'd0, 1'b1, held_b});
      if (tx_valid_b && tx_ready_b) begin
        if (ptr_b >= B_TOTAL) check("b_extra_byte", ptr_b, B_TOTAL - 1);
        else check("b_byte", tx_data_b, exp_byte(B_FIRST, ptr_b));
        ptr_b++;
      end
      stall_b = tx_valid_b && !tx_ready_b;
      held_b  = tx_data_b;
      check("b_hold_eq_busy", hold_cpu_b, busy_b);
      if (done_b) begin
        check("b_done_after_last", ptr_b, B_TOTAL);
        done_cnt_b++;
        ptr_b = 0;
      end
    end
  end

  bit rand_ready = 0;
  initial begin
    tx_ready_a = 1'b1;
    tx_ready_b = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready_a = rand_ready ? ($urandom_range(0, 99) < 40) : 1'b1;
    end
  end

  // Pulse start on DUT a and return cycles from the start edge to the done cycle.
  task automatic run_a(output int cyc);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    cyc = 1;
    while (cyc < 3000) begin
      @(negedge clk);
      if (done_a) break;
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 3000) check("a_done_timeout", 0, 1);
  endtask

  task automatic wait_ptr_a(input int n);
    int k;
    k = 0;
    while (ptr_a != n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) check("a_ptr_timeout", ptr_a, n);
  endtask

  initial begin
    int cyc;
    int dc;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[1]  = 32'h11223344;
    regs[5]  = 32'hCAFEF00D;
    regs[31] = 32'hDEADBEEF;
    reset = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;

    // reset held low with start high
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_tx_valid", tx_valid_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_hold", hold_cpu_a, 0);
      check("rst_rd_addr", rd_addr_a, 0);
      check("rst_tx_data", tx_data_a, 0);
      check("rst_done", done_a, 0);
      check("rst_b_valid", tx_valid_b, 0);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    reset = 1'b1;

    check("pin_x0_byte", exp_byte(A_FIRST, 1), 8'h00);
    check("pin_x1_msb", exp_byte(A_FIRST, 5), 8'h11);
    check("pin_x1_lsb", exp_byte(A_FIRST, 8), 8'h44);
    check("pin_x31_msb", exp_byte(A_FIRST, 125), 8'hDE);
    check("pin_x31_lsb", exp_byte(A_FIRST, 128), 8'hEF);
    check("pin_x5_msb", exp_byte(B_FIRST, 1), 8'hCA);
    check("pin_x5_lsb", exp_byte(B_FIRST, 4), 8'h0D);
    repeat (2) @(posedge clk);

    // full dump, ready always high
    dc = done_cnt_a;
    run_a(cyc);
    check("a_latency", cyc, 162);
    repeat (3) @(posedge clk);
    #1;
    check("a_done_once", done_cnt_a, dc + 1);
    check("a_idle_after", busy_a, 0);

    // single-register dump on dut_b
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      @(negedge clk);
      if (done_b) break;
      @(posedge clk);
      cyc++;
    end
    check("b_latency", cyc, 7);
    @(posedge clk); #1;
    check("b_idle_after", busy_b, 0);
    check("b_done_once", done_cnt_b, 1);

    // ~40% ready duty
    rand_ready = 1;
    dc = done_cnt_a;
    run_a(cyc);
    rand_ready = 0;
    check("a_stalled_slower", (cyc > 162) ? 1 : 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("a_stalled_done_once", done_cnt_a, dc + 1);

    // reset after the 10th byte
    dc = done_cnt_a;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_ptr_a(10);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_tx_valid", tx_valid_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_rd_addr", rd_addr_a, 0);
    check("mid_rst_tx_data", tx_data_a, 0);
    check("mid_rst_done", done_a, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt_a, dc);
    check("mid_rst_stays_idle", busy_a, 0);
    run_a(cyc);
    check("restart_latency", cyc, 162);
    repeat (2) @(posedge clk);
    #1;
    check("restart_done_once", done_cnt_a, dc + 1);

    // start re-pulsed during SEND and in the DONE cycle
    dc = done_cnt_a;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    cyc = 1;
    wait_ptr_a(7);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 3000) check("a_done_timeout2", 0, 1);
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    check("done_start_ignored", busy_a, 0);
    repeat (3) begin
      @(negedge clk);
      check("no_restart_valid", tx_valid_a, 0);
    end
    check("busy_start_done_once", done_cnt_a, dc + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
